softmax_ctrl: RTL and testbench

Phase sequencer for the softmax datapath. Runs one softmax frame of `IFM_SIZE` elements through three passes:
- load/max,
- subtract-exp-accumulate,
- reciprocal and normalize.

It drives the IFM buffer addresses, the per-phase datapath enables and the external handshake (`ifm_read`, `valid_data`, `end_softmax`). It sits between the input stream and the datapath inside the softmax top level.

---
 rtl/softmax_ctrl.sv | 162 ++++++++++++++++
 tb/tb_softmax_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/softmax_ctrl.sv
// Phase sequencer for one softmax frame: load/max, exp/accumulate, reciprocal + normalize.
// Latency: valid_data trails norm_en by PIPE_LAT cycles; LOAD stalls on valid_ifm, RECIP waits on div_done.
module softmax_ctrl #(
   parameter int IFM_SIZE   = 1000,
   parameter int ADDR_WIDTH = 10,
   parameter int PIPE_LAT   = 4
) (
   input  logic                  clk1,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  valid_ifm,
   output logic                  ifm_read,
   output logic                  buf_we,
   output logic [ADDR_WIDTH-1:0] buf_waddr,
   output logic                  buf_re,
   output logic [ADDR_WIDTH-1:0] buf_raddr,
   output logic                  max_clr,
   output logic                  max_en,
   output logic                  sum_clr,
   output logic                  exp_en,
   output logic                  div_start,
   input  logic                  div_done,
   output logic                  norm_en,
   output logic                  valid_data,
   output logic [ADDR_WIDTH-1:0] counter_compute,
   output logic                  busy,
   output logic                  end_softmax
);

   localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = ADDR_WIDTH'(IFM_SIZE - 1);
   localparam logic [DW-1:0]         LAST_DRAIN = DW'(PIPE_LAT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_EXP, S_EXP_DRAIN, S_RECIP, S_NORM, S_NORM_DRAIN, S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic [DW-1:0]         drain_q, drain_d;
   logic                  first_q, first_d;
   logic [PIPE_LAT-1:0]   vpipe_q, vpipe_d;

   always_ff @(posedge clk1) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         drain_q <= '0;
         first_q <= 1'b0;
         vpipe_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         drain_q <= drain_d;
         first_q <= first_d;
         vpipe_q <= vpipe_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      drain_d     = drain_q;
      ifm_read    = 1'b0;
      buf_we      = 1'b0;
      buf_waddr   = '0;
      buf_re      = 1'b0;
      buf_raddr   = '0;
      max_clr     = 1'b0;
      max_en      = 1'b0;
      sum_clr     = 1'b0;
      exp_en      = 1'b0;
      div_start   = 1'b0;
      norm_en     = 1'b0;
      end_softmax = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_LOAD;
               cnt_d   = '0;
               max_clr = 1'b1;
               sum_clr = 1'b1;
            end
         end
         S_LOAD: begin
            ifm_read = 1'b1;
            if (valid_ifm) begin
               buf_we    = 1'b1;
               max_en    = 1'b1;
               buf_waddr = cnt_q;
               if (cnt_q == LAST_IDX) begin
                  cnt_d   = '0;
                  state_d = S_EXP;
               end else begin
                  cnt_d = cnt_q + ADDR_WIDTH'(1);
               end
            end
         end
         S_EXP: begin
            buf_re    = 1'b1;
            exp_en    = 1'b1;
            buf_raddr = cnt_q;
            if (cnt_q == LAST_IDX) begin
               cnt_d   = '0;
               drain_d = '0;
               state_d = S_EXP_DRAIN;
            end else begin
               cnt_d = cnt_q + ADDR_WIDTH'(1);
            end
         end
         S_EXP_DRAIN: begin
            if (drain_q == LAST_DRAIN) begin
               drain_d = '0;
               state_d = S_RECIP;
            end else begin
               drain_d = drain_q + DW'(1);
            end
         end
         S_RECIP: begin
            div_start = first_q;
            if (div_done) state_d = S_NORM;
         end
         S_NORM: begin
            buf_re    = 1'b1;
            norm_en   = 1'b1;
            buf_raddr = cnt_q;
            if (cnt_q == LAST_IDX) begin
               cnt_d   = '0;
               drain_d = '0;
               state_d = S_NORM_DRAIN;
            end else begin
               cnt_d = cnt_q + ADDR_WIDTH'(1);
            end
         end
         S_NORM_DRAIN: begin
            if (drain_q == LAST_DRAIN) begin
               drain_d = '0;
               state_d = S_DONE;
            end else begin
               drain_d = drain_q + DW'(1);
            end
         end
         S_DONE: begin
            end_softmax = 1'b1;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Marks only the entry cycle of RECIP so div_start is a single pulse.
      first_d = (state_d == S_RECIP) && (state_q != S_RECIP);

      vpipe_d[0] = norm_en;
      for (int i = 1; i < PIPE_LAT; i++) vpipe_d[i] = vpipe_q[i-1];
   end

   assign valid_data      = vpipe_q[PIPE_LAT-1];
   assign counter_compute = cnt_q;
   assign busy            = (state_q != S_IDLE);

endmodule

// File: tb/tb_softmax_ctrl.sv
// Bench for softmax_ctrl: per-cycle comparison against a timeline model of the frame phases.
module tb_softmax_ctrl;

   localparam int N    = 8;
   localparam int L    = 3;
   localparam int AW   = 4;
   localparam int MAXC = 200;
   localparam int OW   = 24;

   logic          clk1 = 1'b0;
   logic          rst, start, valid_ifm, div_done;
   logic          ifm_read, buf_we, buf_re, max_clr, max_en, sum_clr, exp_en;
   logic          div_start, norm_en, valid_data, busy, end_softmax;
   logic [AW-1:0] buf_waddr, buf_raddr, counter_compute;
   logic [OW-1:0] obs;

   always #5 clk1 = ~clk1;

   softmax_ctrl #(.IFM_SIZE(N), .ADDR_WIDTH(AW), .PIPE_LAT(L)) dut (
      .clk1(clk1), .rst(rst), .start(start), .valid_ifm(valid_ifm),
      .ifm_read(ifm_read), .buf_we(buf_we), .buf_waddr(buf_waddr),
      .buf_re(buf_re), .buf_raddr(buf_raddr), .max_clr(max_clr),
      .max_en(max_en), .sum_clr(sum_clr), .exp_en(exp_en),
      .div_start(div_start), .div_done(div_done), .norm_en(norm_en),
      .valid_data(valid_data), .counter_compute(counter_compute),
      .busy(busy), .end_softmax(end_softmax)
   );

   assign obs = {ifm_read, buf_we, buf_waddr, buf_re, buf_raddr, max_clr, max_en,
                 sum_clr, exp_en, div_start, norm_en, valid_data, counter_compute,
                 busy, end_softmax};

   typedef struct {
      int vmode;    // 0: valid always, 1: pattern 1,0,0, 2: random
      int dly;      // div_done delay after div_start; -1: div_done held high all frame
      bit noise;    // spurious start/valid_ifm/div_done
      int exp_len;  // expected frame length in cycles; -1: taken from the model
      int exp_vd;
   } row_t;

   int nchecks = 0, nerrors = 0, frame_no = 0;
   bit vi[MAXC], st[MAXC], dd[MAXC];
   row_t rows[10];

   task automatic check(input string name, input int c, input logic [OW-1:0] got, input logic [OW-1:0] want);
      nchecks++;
      if (got !== want) begin
         nerrors++;
         $display("FAIL %s frame %0d cycle %0d: got %h, expected %h", name, frame_no, c, got, want);
      end
   endtask

   task automatic check_int(input string name, input int got, input int want);
      nchecks++;
      if (got != want) begin
         nerrors++;
         $display("FAIL %s frame %0d: got %0d, expected %0d", name, frame_no, got, want);
      end
   endtask

   task automatic idle_check(input int n);
      for (int i = 0; i < n; i++) begin
         start     = 1'b0;
         valid_ifm = 1'($urandom_range(0, 1));
         div_done  = 1'($urandom_range(0, 1));
         @(negedge clk1);
         check("idle", i, obs, '0);
         @(posedge clk1); #1;
      end
   endtask

   // Model: phase windows derived from N, L, the accept times and the div_done time.
   task automatic run_frame(input int vmode, input int dly, input bit noise, input int abort_v,
                            output int flen, output int vcnt, output int mlen);
      int load_end, r0, n0, e0, fend, acc, abort_c;
      bit in_load, in_exp, in_norm, we, vd;
      logic [AW-1:0] wa, ra, cc;
      logic [OW-1:0] want;

      for (int c = 0; c < MAXC; c++) begin
         case (vmode)
            0:       vi[c] = 1'b1;
            1:       vi[c] = (c >= 1) && ((c - 1) % 3 == 0);
            default: vi[c] = ($urandom_range(0, 3) != 0) || (c >= 100);
         endcase
      end
      acc = 0;
      load_end = 0;
      for (int c = 1; c < MAXC; c++) begin
         if (vi[c]) acc++;
         if (acc == N) begin
            load_end = c;
            break;
         end
      end
      e0   = load_end + 1;
      r0   = load_end + N + L + 1;
      n0   = r0 + ((dly < 0) ? 1 : dly + 1);
      fend = n0 + N + L;
      mlen = fend + 1;
      abort_c = (abort_v >= 0) ? n0 + L + abort_v - 1 : -1;
      for (int c = 0; c < MAXC; c++) begin
         if (dly < 0) dd[c] = 1'b1;
         else dd[c] = (c == r0 + dly) ||
                      (noise && (c < r0 || c > r0 + dly) && ($urandom_range(0, 1) == 1));
         st[c] = (c == 0) ||
                 (noise && c <= fend && ((c >= e0 && c < e0 + N) || ($urandom_range(0, 1) == 1)));
      end

      acc  = 0;
      flen = -1;
      vcnt = 0;
      for (int c = 0; c <= fend; c++) begin
         start     = st[c];
         valid_ifm = vi[c];
         div_done  = dd[c];
         if (c == abort_c) rst = 1'b1;
         in_load = (c >= 1) && (c <= load_end);
         in_exp  = (c >= e0) && (c < e0 + N);
         in_norm = (c >= n0) && (c < n0 + N);
         we      = in_load && vi[c];
         vd      = (c >= n0 + L) && (c < n0 + L + N);
         wa      = we ? AW'(acc) : '0;
         ra      = in_exp ? AW'(c - e0) : (in_norm ? AW'(c - n0) : '0);
         cc      = in_load ? AW'(acc) : ra;
         want = {in_load, we, wa, in_exp || in_norm, ra, c == 0, we, c == 0, in_exp,
                 c == r0, in_norm, vd, cc, c >= 1, c == fend};
         @(negedge clk1);
         check("outputs", c, obs, want);
         if (valid_data) vcnt++;
         if (end_softmax && flen < 0) flen = c + 1;
         if (we) acc++;
         @(posedge clk1); #1;
         if (c == abort_c) begin
            rst = 1'b0;
            break;
         end
      end
   endtask

   initial begin
      int fl, vc, ml;
      rows[0] = '{0,  2, 1'b0, 35, N};
      rows[1] = '{1,  2, 1'b0, 49, N};
      rows[2] = '{0, -1, 1'b0, 33, N};
      rows[3] = '{0,  2, 1'b1, 35, N};
      for (int i = 4; i < 10; i++) rows[i] = '{2, int'($urandom_range(0, 3)), 1'b1, -1, N};

      rst = 1'b1; start = 1'b0; valid_ifm = 1'b1; div_done = 1'b1;
      repeat (2) @(posedge clk1);
      @(negedge clk1);
      check("reset", 0, obs, '0);
      @(posedge clk1); #1;
      rst = 1'b0;
      idle_check(2);

      for (int r = 0; r < 10; r++) begin
         frame_no++;
         run_frame(rows[r].vmode, rows[r].dly, rows[r].noise, -1, fl, vc, ml);
         check_int("frame_len", fl, (rows[r].exp_len >= 0) ? rows[r].exp_len : ml);
         check_int("valid_count", vc, rows[r].exp_vd);
         idle_check(2);
      end

      // Back-to-back: start lands in the cycle right after end_softmax.
      for (int k = 0; k < 2; k++) begin
         frame_no++;
         run_frame(0, 2, 1'b0, -1, fl, vc, ml);
         check_int("b2b_len", fl, 35);
         check_int("b2b_valid", vc, N);
      end
      idle_check(2);

      // Reset during NORM after four valid_data, then a clean frame.
      frame_no++;
      run_frame(0, 2, 1'b0, 4, fl, vc, ml);
      check_int("abort_end", fl, -1);
      check_int("abort_valid", vc, 4);
      idle_check(6);
      frame_no++;
      run_frame(0, 2, 1'b0, -1, fl, vc, ml);
      check_int("post_abort_len", fl, 35);
      check_int("post_abort_valid", vc, N);
      idle_check(2);

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

endmodule
